// File: rtl/hdmi_mode_pkg.sv
// Shared types, widths and the raw per-mode timing table for the HDMI mode controller.
package hdmi_mode_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    MODE_1080P   = 2'd0,
    MODE_720P    = 2'd1,
    MODE_480P    = 2'd2,
    MODE_640X480 = 2'd3
  } mode_t;

  localparam int TIMING_W  = 12;
  localparam int PATTERN_W = 8;
  localparam int RAMP_W    = 20;

  // Raw line/frame timing as published for each mode, before derivation.
  typedef struct packed {
    logic [TIMING_W-1:0] total;
    logic [TIMING_W-1:0] fp;
    logic [TIMING_W-1:0] bp;
    logic [TIMING_W-1:0] sync;
  } timing_t;

  localparam mode_t                RESET_MODE    = MODE_1080P;
  localparam logic [PATTERN_W-1:0] RESET_PATTERN = 8'd4;

  function automatic timing_t mode_h_timing(input mode_t mode);
    case (mode)
      MODE_1080P: return '{12'd2200, 12'd88,  12'd148, 12'd44};
      MODE_720P:  return '{12'd1650, 12'd110, 12'd220, 12'd40};
      MODE_480P:  return '{12'd858,  12'd16,  12'd60,  12'd62};
      default:    return '{12'd800,  12'd16,  12'd48,  12'd96};
    endcase
  endfunction

  function automatic timing_t mode_v_timing(input mode_t mode);
    case (mode)
      MODE_1080P: return '{12'd1125, 12'd4,  12'd36, 12'd5};
      MODE_720P:  return '{12'd750,  12'd5,  12'd20, 12'd5};
      MODE_480P:  return '{12'd525,  12'd9,  12'd30, 12'd6};
      default:    return '{12'd525,  12'd10, 12'd33, 12'd2};
    endcase
  endfunction

  // Per-pixel increment that makes a test ramp span one active line.
  function automatic logic [RAMP_W-1:0] mode_ramp_step(input mode_t mode);
    case (mode)
      MODE_1080P: return 20'd546;
      MODE_720P:  return 20'd819;
      MODE_480P:  return 20'd1456;
      default:    return 20'd1638;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_mode_rom.sv
// Combinational mode table: turns a mode number into the sync generator
// thresholds and the active-area size / ramp step for the pattern generator.
module hdmi_mode_rom
  import hdmi_mode_pkg::*;
#(
  parameter int WIDTH_ADDR  = 12,
  parameter int HEIGHT_ADDR = 12
) (
  input  logic [1:0]                               mode,
  output logic [4*WIDTH_ADDR+4*HEIGHT_ADDR-1:0]    sync_cfg,
  output logic [WIDTH_ADDR-1:0]                    active_pixels,
  output logic [HEIGHT_ADDR-1:0]                   active_lines,
  output logic [RAMP_W-1:0]                        ramp_step
);

  timing_t h_t;
  timing_t v_t;

  logic [WIDTH_ADDR-1:0]  h_end, h_front_end, h_back_sync, h_fp, h_bp, h_sync_w;
  logic [HEIGHT_ADDR-1:0] v_end, v_front_end, v_back_sync, v_fp, v_bp, v_sync_w;

  // Derive counter thresholds from raw timing; all arithmetic wraps at the field width.
  always_comb begin
    h_t = mode_h_timing(mode_t'(mode));
    v_t = mode_v_timing(mode_t'(mode));

    h_fp        = WIDTH_ADDR'(h_t.fp);
    h_bp        = WIDTH_ADDR'(h_t.bp);
    h_sync_w    = WIDTH_ADDR'(h_t.sync);
    h_end       = WIDTH_ADDR'(h_t.total) - WIDTH_ADDR'(1);
    h_front_end = h_end - h_fp;
    h_back_sync = h_bp + h_sync_w;

    v_fp        = HEIGHT_ADDR'(v_t.fp);
    v_bp        = HEIGHT_ADDR'(v_t.bp);
    v_sync_w    = HEIGHT_ADDR'(v_t.sync);
    v_end       = HEIGHT_ADDR'(v_t.total) - HEIGHT_ADDR'(1);
    v_front_end = v_end - v_fp;
    v_back_sync = v_bp + v_sync_w;

    active_pixels = h_end - (h_fp + h_bp + h_sync_w);
    active_lines  = v_end - (v_fp + v_bp + v_sync_w);
    ramp_step     = mode_ramp_step(mode_t'(mode));

    sync_cfg = {h_end, h_front_end, h_back_sync, h_sync_w,
                v_end, v_front_end, v_back_sync, v_sync_w};
  end

endmodule

// File: rtl/hdmi_mode_ctrl.sv
// HDMI mode controller: programs the sync and pattern generators, waits for
// them to settle, then gates video out until a mode/pattern change request,
// which is applied at the next frame boundary.
module hdmi_mode_ctrl
  import hdmi_mode_pkg::*;
#(
  parameter int WIDTH_ADDR    = 12,
  parameter int HEIGHT_ADDR   = 12,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                                            CLK,
  input  logic                                            RST,
  input  logic                                            modeReq__ENA,
  input  logic [1:0]                                      modeReq_mode,
  input  logic                                            patternReq__ENA,
  input  logic [PATTERN_W-1:0]                            patternReq_pattern,
  output logic                                            req__RDY,
  input  logic                                            vSync,
  input  logic                                            syncSetup__RDY,
  input  logic                                            patSetup__RDY,
  output logic                                            setup__ENA,
  output logic [4*WIDTH_ADDR+4*HEIGHT_ADDR-1:0]           syncCfg,
  output logic [WIDTH_ADDR+HEIGHT_ADDR+PATTERN_W+RAMP_W-1:0] patCfg,
  output logic                                            outEnable,
  output logic [1:0]                                      curMode
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t               state_q, state_d;
  mode_t                lat_mode, cur_mode;
  logic [PATTERN_W-1:0] lat_pattern;
  logic [7:0]           settle_cnt;
  logic                 vsync_q;
  logic                 vsync_rise;
  logic                 setup_ena;
  logic                 in_run;

  logic [4*WIDTH_ADDR+4*HEIGHT_ADDR-1:0] rom_sync_cfg;
  logic [WIDTH_ADDR-1:0]                 rom_active_pixels;
  logic [HEIGHT_ADDR-1:0]                rom_active_lines;
  logic [RAMP_W-1:0]                     rom_ramp_step;

  hdmi_mode_rom #(
    .WIDTH_ADDR  (WIDTH_ADDR),
    .HEIGHT_ADDR (HEIGHT_ADDR)
  ) u_rom (
    .mode          (lat_mode),
    .sync_cfg      (rom_sync_cfg),
    .active_pixels (rom_active_pixels),
    .active_lines  (rom_active_lines),
    .ramp_step     (rom_ramp_step)
  );

  assign in_run     = (state_q == ST_RUN);
  assign vsync_rise = vSync & ~vsync_q;

  // State register plus request latches, settle counter and vSync history.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      lat_mode    <= RESET_MODE;
      lat_pattern <= RESET_PATTERN;
      cur_mode    <= RESET_MODE;
      settle_cnt  <= 8'd0;
      vsync_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vSync;
      if (state_q == ST_SETTLE) begin
        settle_cnt <= settle_cnt + 8'd1;
      end else begin
        settle_cnt <= 8'd0;
      end
      if (setup_ena) begin
        cur_mode <= lat_mode;
      end
      if (in_run && modeReq__ENA) begin
        lat_mode <= mode_t'(modeReq_mode);
      end
      if (in_run && patternReq__ENA) begin
        lat_pattern <= patternReq_pattern;
      end
    end
  end

  // Next-state logic and the one-cycle setup strobe.
  always_comb begin
    state_d   = state_q;
    setup_ena = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = ST_SETUP;
      ST_SETUP: begin
        if (syncSetup__RDY && patSetup__RDY) begin
          setup_ena = 1'b1;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (modeReq__ENA || patternReq__ENA) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (vsync_rise) begin
          state_d = ST_SETUP;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  assign setup__ENA = setup_ena;
  assign req__RDY   = in_run;
  assign outEnable  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign curMode    = cur_mode;
  assign syncCfg    = setup_ena ? rom_sync_cfg : '0;
  assign patCfg     = setup_ena ? {rom_active_pixels, rom_active_lines, lat_pattern, rom_ramp_step} : '0;

endmodule

// File: doc/hdmi_mode_ctrl.md
HDMI_MODE_CTRL -- requirements
Module: hdmi_mode_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_ADDR, default 12: width of every horizontal timing field.
REQ-002 SHALL have parameter HEIGHT_ADDR, default 12: width of every vertical timing field.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 16 (valid 1..255): cycles between setup and output enable.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: `CLK  in  1  rising-edge clock`.
REQ-005 SHALL have `RST  in  1  asynchronous active-high reset`.
REQ-006 SHALL have `modeReq__ENA  in  1  mode-change request strobe`.
REQ-007 SHALL have `modeReq$mode  in  2  requested mode: 0=1080p60, 1=720p60, 2=480p60, 3=640x480p60`.
REQ-008 SHALL have `patternReq__ENA  in  1  pattern-change request strobe`.
REQ-009 SHALL have `patternReq$pattern  in  8  requested pattern code`.
REQ-010 SHALL have `req__RDY  out  1  both requests acceptable`.
REQ-011 SHALL have `vSync  in  1  vertical sync from the sync generator`.
REQ-012 SHALL have `syncSetup__RDY  in  1  sync generator ready for setup`.
REQ-013 SHALL have `patSetup__RDY  in  1  pattern generator ready for setup`.
REQ-014 SHALL have `setup__ENA  out  1  one-cycle setup strobe to both generators`.
REQ-015 SHALL have `syncCfg  out  96  {hEnd,hFrontEnd,hBackSync,hSyncWidth,vEnd,vFrontEnd,vBackSync,vSyncWidth}, MSB first`.
REQ-016 SHALL have `patCfg  out  52  {activePixels[12],activeLines[12],pattern[8],rampStep[20]}`.
REQ-017 SHALL have `outEnable  out  1  gate for video outputs`.
REQ-018 SHALL have `curMode  out  2  mode currently programmed`.

Function
REQ-019 SHALL implement the FSM states IDLE, SETUP, SETTLE, RUN and DRAIN.
REQ-020 SHALL move IDLE->SETUP unconditionally on the first clock after reset, using mode 0 and pattern 4.
REQ-021 SHALL, in SETUP, assert setup__ENA for exactly the one cycle in which syncSetup__RDY && patSetup__RDY, then enter SETTLE; SETUP SHALL wait indefinitely otherwise.
REQ-022 SHALL drive syncCfg and patCfg to zero whenever setup__ENA=0.
REQ-023 SHALL take per-mode values (total, fp, bp, sync) as follows. H: 1080p {2200,88,148,44}, 720p {1650,110,220,40}, 480p {858,16,60,62}, 640 {800,16,48,96}. V: 1080p {1125,4,36,5}, 720p {750,5,20,5}, 480p {525,9,30,6}, 640 {525,10,33,2}.
REQ-024 SHALL derive End=total-1, FrontEnd=End-fp, BackSync=bp+sync, SyncWidth=sync, activePixels=hEnd-(hfp+hbp+hsync) and activeLines=vEnd-(vfp+vbp+vsync), all modulo 2^12.
REQ-025 SHALL set rampStep per mode as 546, 819, 1456 and 1638 for modes 0..3.
REQ-026 SHALL, in SETTLE, count SETTLE_CYCLES cycles: setup__ENA at cycle t puts SETTLE on t+1..t+SETTLE_CYCLES and RUN on t+SETTLE_CYCLES+1.
REQ-027 SHALL drive outEnable=1 only in RUN and DRAIN.
REQ-028 SHALL drive req__RDY=1 only in RUN.
REQ-029 SHALL latch a request accepted in RUN and enter DRAIN.
REQ-030 SHALL, when modeReq__ENA and patternReq__ENA are accepted in the same cycle, latch both and perform a single reconfiguration.
REQ-031 SHALL leave the unrequested field unchanged when only one request is accepted.
REQ-032 SHALL ignore request strobes outside RUN (no latch, no effect).
REQ-033 SHALL, in DRAIN, detect a vSync rising edge (registered previous value); the cycle after detection outEnable=0 and state=SETUP.
REQ-034 SHALL update curMode in the setup__ENA cycle; it SHALL hold the previous mode through DRAIN.
REQ-035 SHALL keep a vSync edge that coincides with request acceptance from completing the drain; only later edges count.

Reset
REQ-036 SHALL, while RST=1, immediately force: state=IDLE, setup__ENA=0, syncCfg=0, patCfg=0, outEnable=0, req__RDY=0, curMode=0, latched mode=0, latched pattern=4, settle counter=0, vSync history=0.
REQ-037 SHALL, on RST asserted mid-SETTLE or mid-DRAIN, discard the pending request; after release it restarts per REQ-020.

Structure
REQ-038 SHALL place the state enum, mode enum, timing struct, cfg packing widths and mode constants in shared package hdmi_mode_pkg.
REQ-039 SHALL implement the mode table (REQ-023..025) as combinational sub-module hdmi_mode_rom: mode in, packed syncCfg/patCfg values out.

Verification
REQ-040 Bench SHALL cover: reset release with both RDY=1 -> setup__ENA on cycle 1, hEnd=2199, hFrontEnd=2111, hBackSync=192, activePixels=1919, activeLines=1079, pattern=4, rampStep=546; outEnable rises cycle 18 (SETTLE_CYCLES=16).
REQ-041 Bench SHALL cover: mode 1 request in RUN -> outEnable stays 1 until the next vSync rise, then setup with hEnd=1649, activePixels=1279, vEnd=749, activeLines=719, rampStep=819.
REQ-042 Bench SHALL cover: simultaneous modeReq=2 and patternReq=7 -> exactly one setup__ENA pulse, hEnd=857, activePixels=719, pattern=7.
REQ-043 Bench SHALL cover: patSetup__RDY held 0 for 50 cycles in SETUP -> setup__ENA=0 and cfg=0 throughout; pulse occurs on the first cycle both RDY=1.
REQ-044 Bench SHALL cover: RST pulsed mid-DRAIN with mode 3 pending -> outputs zero asynchronously; after release the mode 0 setup recurs and curMode=0.
REQ-045 Bench SHALL cover: request strobes during SETTLE -> ignored, curMode unchanged.
